// File: rtl/timer_slot_scheduler.sv
// -----------------------------------------------------------------------------
// timer_slot_scheduler
//
// Multiplexes NUM_SLOTS software deadlines onto the single compare channel of
// machine_timer. Each slot keeps a remaining-tick count. The scheduler finds the
// earliest armed deadline and programs the timer for it over a simple
// single-cycle register bus (ctrl 0x0, cmp 0x4, count 0x8). When the timer
// fires, the scheduler stops the timer and ages every slot by the elapsed
// ticks. It then raises sticky per-slot expiry flags and reloads periodic
// slots.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cfg_valid_i/ready : slot configuration handshake (see below)
//   cfg_slot_i        : slot index to configure
//   cfg_enable_i      : 1 = arm slot, 0 = disarm slot
//   cfg_periodic_i    : reload the slot with its period after each expiry
//   cfg_delay_i       : delay/period in timer ticks (0 is treated as 1)
//   expired_o         : sticky expiry flags, one bit per slot
//   expired_clr_i     : per-bit clear of expired_o (a same-cycle set wins)
//   irq_o             : OR of expired_o, registered alongside it
//   tmr_addr_o/data_o : timer bus address / write data
//   tmr_sel_o/we_o    : timer bus byte selects / write strobe
//   tmr_data_i        : timer read data, valid the cycle after the address
//   tmr_irq_i         : timer interrupt
//
// Handshake: a config request transfers on a rising clk edge where
// cfg_valid_i and cfg_ready_o are both 1. cfg_ready_o does not depend on
// cfg_valid_i. It is high in IDLE, and in WAIT unless tmr_irq_i is high in
// that same cycle, because the interrupt path takes priority.
//
// The bus outputs and cfg_ready_o decode the current state. They are forced
// to zero while rst is high. The timer therefore sees the INIT stop-write in
// the first cycle after rst is released.
// -----------------------------------------------------------------------------
module timer_slot_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [SW-1:0]        cfg_slot_i,
  input  logic                 cfg_enable_i,
  input  logic                 cfg_periodic_i,
  input  logic [31:0]          cfg_delay_i,
  output logic [NUM_SLOTS-1:0] expired_o,
  input  logic [NUM_SLOTS-1:0] expired_clr_i,
  output logic                 irq_o,
  output logic [31:0]          tmr_addr_o,
  output logic [31:0]          tmr_data_o,
  output logic [3:0]           tmr_sel_o,
  output logic                 tmr_we_o,
  input  logic [31:0]          tmr_data_i,
  input  logic                 tmr_irq_i
);

  localparam logic [31:0] ADDR_CTRL  = 32'h0;
  localparam logic [31:0] ADDR_CMP   = 32'h4;
  localparam logic [31:0] ADDR_COUNT = 32'h8;
  // ctrl bit0 = run, bit1 = stop + clear pending
  localparam logic [31:0] CTRL_STOP  = 32'h2;
  localparam logic [31:0] CTRL_RUN   = 32'h1;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_IDLE   = 4'd1,
    S_SCAN   = 4'd2,
    S_STOP   = 4'd3,
    S_WCMP   = 4'd4,
    S_START  = 4'd5,
    S_WAIT   = 4'd6,
    S_RDCNT  = 4'd7,
    S_RDWAIT = 4'd8,
    S_ACK    = 4'd9,
    S_UPDATE = 4'd10
  } state_e;

  state_e r_state;
  state_e w_next;

  // Per-slot state
  logic [NUM_SLOTS-1:0] r_en;
  logic [NUM_SLOTS-1:0] r_periodic;
  logic [31:0]          r_period [NUM_SLOTS];
  logic [31:0]          r_remain [NUM_SLOTS];

  // Scan / programming state
  logic [SW-1:0]        r_scan_idx;
  logic                 r_found;
  logic [31:0]          r_min;
  logic [31:0]          r_prog;
  logic [31:0]          r_elapsed;

  // Config captured in WAIT. It is applied in RDWAIT, after the counter read.
  logic [SW-1:0]        r_cfg_slot;
  logic                 r_cfg_en;
  logic                 r_cfg_periodic;
  logic [31:0]          r_cfg_delay;
  logic                 r_skip;      // r_cfg_slot is excluded from the next aging

  logic [NUM_SLOTS-1:0] r_expired;
  logic                 r_irq;

  // Combinational helpers
  logic                 w_accept;
  logic                 w_any_en;
  logic                 w_scan_take;
  logic                 w_scan_last;
  logic                 w_apply;
  logic [SW-1:0]        w_apply_slot;
  logic                 w_apply_en;
  logic                 w_apply_periodic;
  logic [31:0]          w_apply_raw;
  logic [31:0]          w_apply_delay;
  logic [31:0]          w_aged [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_age;
  logic [NUM_SLOTS-1:0] w_set;
  logic [NUM_SLOTS-1:0] w_expired_next;

  assign w_accept    = cfg_valid_i & cfg_ready_o;
  assign w_any_en    = |r_en;
  assign w_scan_last = (r_scan_idx == SW'(NUM_SLOTS - 1));
  // The first armed slot seeds the minimum. Later slots replace it only when
  // strictly smaller.
  assign w_scan_take = r_en[r_scan_idx] &&
                       (!r_found || (r_remain[r_scan_idx] < r_min));

  // The same apply path serves both config sources. In IDLE the live request
  // is applied. In RDWAIT the request latched in WAIT is applied.
  always_comb begin : p_apply_mux
    w_apply          = 1'b0;
    w_apply_slot     = cfg_slot_i;
    w_apply_en       = cfg_enable_i;
    w_apply_periodic = cfg_periodic_i;
    w_apply_raw      = cfg_delay_i;
    if (r_state == S_RDWAIT) begin
      w_apply          = 1'b1;
      w_apply_slot     = r_cfg_slot;
      w_apply_en       = r_cfg_en;
      w_apply_periodic = r_cfg_periodic;
      w_apply_raw      = r_cfg_delay;
    end else if ((r_state == S_IDLE) && w_accept) begin
      w_apply = 1'b1;
    end
    w_apply_delay = (w_apply_raw == 32'd0) ? 32'd1 : w_apply_raw;
  end

  // Saturating age of each slot by the elapsed tick count
  always_comb begin : p_age
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_aged[i] = (r_remain[i] > r_elapsed) ? (r_remain[i] - r_elapsed) : 32'd0;
      w_age[i]  = (r_state == S_UPDATE) && r_en[i] &&
                  !(r_skip && (r_cfg_slot == SW'(i)));
      w_set[i]  = w_age[i] && (w_aged[i] == 32'd0);
    end
  end

  assign w_expired_next = (r_expired & ~expired_clr_i) | w_set;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : p_next
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_IDLE;
      S_IDLE:   if (w_accept || w_any_en) w_next = S_SCAN;
      S_SCAN:   if (w_scan_last) w_next = (r_found || w_scan_take) ? S_STOP : S_IDLE;
      S_STOP:   w_next = S_WCMP;
      S_WCMP:   w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT: begin
        if (tmr_irq_i)     w_next = S_ACK;
        else if (w_accept) w_next = S_RDCNT;
      end
      S_RDCNT:  w_next = S_RDWAIT;
      S_RDWAIT: w_next = S_ACK;
      S_ACK:    w_next = S_UPDATE;
      S_UPDATE: w_next = S_SCAN;
      default:  w_next = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (bus cycle and ready), all zero while in reset
  // ---------------------------------------------------------------------------
  always_comb begin : p_out
    cfg_ready_o = 1'b0;
    tmr_we_o    = 1'b0;
    tmr_sel_o   = 4'h0;
    tmr_addr_o  = 32'h0;
    tmr_data_o  = 32'h0;
    if (!rst) begin
      case (r_state)
        S_INIT, S_STOP, S_ACK: begin
          tmr_we_o   = 1'b1;
          tmr_sel_o  = 4'hF;
          tmr_addr_o = ADDR_CTRL;
          tmr_data_o = CTRL_STOP;
        end
        S_WCMP: begin
          // r_min >= 1 always, so this never wraps
          tmr_we_o   = 1'b1;
          tmr_sel_o  = 4'hF;
          tmr_addr_o = ADDR_CMP;
          tmr_data_o = r_min - 32'd1;
        end
        S_START: begin
          tmr_we_o   = 1'b1;
          tmr_sel_o  = 4'hF;
          tmr_addr_o = ADDR_CTRL;
          tmr_data_o = CTRL_RUN;
        end
        S_RDCNT: begin
          tmr_sel_o  = 4'hF;
          tmr_addr_o = ADDR_COUNT;
        end
        S_IDLE:  cfg_ready_o = 1'b1;
        S_WAIT:  cfg_ready_o = !tmr_irq_i;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : p_data
    if (rst) begin
      r_en           <= '0;
      r_periodic     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_period[i] <= 32'd0;
        r_remain[i] <= 32'd0;
      end
      r_scan_idx     <= '0;
      r_found        <= 1'b0;
      r_min          <= 32'd0;
      r_prog         <= 32'd0;
      r_elapsed      <= 32'd0;
      r_cfg_slot     <= '0;
      r_cfg_en       <= 1'b0;
      r_cfg_periodic <= 1'b0;
      r_cfg_delay    <= 32'd0;
      r_skip         <= 1'b0;
      r_expired      <= '0;
      r_irq          <= 1'b0;
    end else begin
      // Sequential minimum search. The search restarts each time SCAN is entered.
      if (r_state == S_SCAN) begin
        if (w_scan_take) begin
          r_min   <= r_remain[r_scan_idx];
          r_found <= 1'b1;
        end
        if (!w_scan_last) r_scan_idx <= r_scan_idx + 1'b1;
      end else begin
        r_scan_idx <= '0;
        r_found    <= 1'b0;
      end

      if (r_state == S_START) r_prog <= r_min;

      if (r_state == S_WAIT) begin
        if (tmr_irq_i) begin
          r_elapsed <= r_prog;
          r_skip    <= 1'b0;
        end else if (w_accept) begin
          r_cfg_slot     <= cfg_slot_i;
          r_cfg_en       <= cfg_enable_i;
          r_cfg_periodic <= cfg_periodic_i;
          r_cfg_delay    <= cfg_delay_i;
          r_skip         <= 1'b1;
        end
      end

      // If the compare fired while the counter was being read, the counter
      // value is stale and the programmed deadline is the elapsed time.
      if (r_state == S_RDWAIT) r_elapsed <= tmr_irq_i ? r_prog : tmr_data_i;

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_apply && (w_apply_slot == SW'(i))) begin
          r_en[i] <= w_apply_en;
          if (w_apply_en) begin
            r_periodic[i] <= w_apply_periodic;
            r_period[i]   <= w_apply_delay;
            r_remain[i]   <= w_apply_delay;
          end
        end else if (w_age[i]) begin
          if (w_aged[i] == 32'd0) begin
            if (r_periodic[i]) begin
              r_remain[i] <= r_period[i];
            end else begin
              r_en[i]     <= 1'b0;
              r_remain[i] <= 32'd0;
            end
          end else begin
            r_remain[i] <= w_aged[i];
          end
        end
      end

      r_expired <= w_expired_next;
      r_irq     <= |w_expired_next;
    end
  end

  assign expired_o = r_expired;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_timer_slot_scheduler.sv
// -----------------------------------------------------------------------------
// Directed bench for timer_slot_scheduler. Expected timer bus cycles are queued
// when a stimulus step is driven. A negedge monitor pops and compares them as
// the DUT issues them. Flag/ready checks use constants derived from the
// scenario.
// -----------------------------------------------------------------------------
module tb_timer_slot_scheduler;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [SW-1:0] cfg_slot_i;
  logic          cfg_enable_i;
  logic          cfg_periodic_i;
  logic [31:0]   cfg_delay_i;
  logic [N-1:0]  expired_o;
  logic [N-1:0]  expired_clr_i;
  logic          irq_o;
  logic [31:0]   tmr_addr_o;
  logic [31:0]   tmr_data_o;
  logic [3:0]    tmr_sel_o;
  logic          tmr_we_o;
  logic [31:0]   tmr_data_i;
  logic          tmr_irq_i;

  timer_slot_scheduler #(.NUM_SLOTS(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_slot_i     (cfg_slot_i),
    .cfg_enable_i   (cfg_enable_i),
    .cfg_periodic_i (cfg_periodic_i),
    .cfg_delay_i    (cfg_delay_i),
    .expired_o      (expired_o),
    .expired_clr_i  (expired_clr_i),
    .irq_o          (irq_o),
    .tmr_addr_o     (tmr_addr_o),
    .tmr_data_o     (tmr_data_o),
    .tmr_sel_o      (tmr_sel_o),
    .tmr_we_o       (tmr_we_o),
    .tmr_data_i     (tmr_data_i),
    .tmr_irq_i      (tmr_irq_i)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;
  // {we, sel, addr, data}
  logic [68:0] exp_q[$];

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] wr(input logic [31:0] a, input logic [31:0] d);
    return {1'b1, 4'hF, a, d};
  endfunction

  function automatic logic [68:0] rd(input logic [31:0] a);
    return {1'b0, 4'hF, a, 32'h0};
  endfunction

  // Every non-idle bus cycle must match the head of the expected queue
  always @(negedge clk) begin
    logic [68:0] e;
    if (!rst && (tmr_we_o || (tmr_addr_o != 32'h0))) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 69'h0;
      chk("bus", {tmr_we_o, tmr_sel_o, tmr_addr_o, tmr_data_o}, e);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 69'(exp_q.size()), 69'd0);
    exp_q.delete();
  endtask

  task automatic do_cfg(input logic [SW-1:0] s, input logic e, input logic p,
                        input logic [31:0] d);
    logic acc = 1'b0;
    cfg_valid_i    = 1'b1;
    cfg_slot_i     = s;
    cfg_enable_i   = e;
    cfg_periodic_i = p;
    cfg_delay_i    = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cfg_ready_o) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid_i = 1'b0;
    chk("cfg_accept", 69'(acc), 69'd1);
  endtask

  // Called in a WAIT cycle. Pulses the timer irq and optionally drives
  // expired_clr_i during the UPDATE cycle, two cycles later.
  task automatic fire_irq(input logic [N-1:0] clr);
    tmr_irq_i = 1'b1;
    @(posedge clk); #1;            // ACK
    tmr_irq_i = 1'b0;
    @(posedge clk); #1;            // UPDATE
    expired_clr_i = clr;
    @(posedge clk); #1;            // SCAN, flags now updated
    expired_clr_i = '0;
    drain();
  endtask

  task automatic clear_all();
    expired_clr_i = '1;
    settle(1);
    expired_clr_i = '0;
    chk("expired_cleared", 69'(expired_o), 69'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    rst            = 1'b1;
    cfg_valid_i    = 1'b0;
    cfg_slot_i     = '0;
    cfg_enable_i   = 1'b0;
    cfg_periodic_i = 1'b0;
    cfg_delay_i    = 32'd0;
    expired_clr_i  = '0;
    tmr_data_i     = 32'd0;
    tmr_irq_i      = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {tmr_we_o, tmr_sel_o, tmr_addr_o, tmr_data_o}, 69'd0);
    chk("rst_ready", 69'(cfg_ready_o), 69'd0);
    chk("rst_expired", 69'(expired_o), 69'd0);
    chk("rst_irq", 69'(irq_o), 69'd0);
    @(posedge clk); #1;
    exp_q.push_back(wr(32'h0, 32'h2));
    rst = 1'b0;
    drain();
    chk("idle_ready", 69'(cfg_ready_o), 69'd1);

    // 1: slot0 one-shot 100
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd99));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd0, 1'b1, 1'b0, 32'd100);
    drain();
    chk("wait_ready", 69'(cfg_ready_o), 69'd1);
    exp_q.push_back(wr(32'h0, 32'h2));
    fire_irq('0);
    settle(6);
    chk("t1_expired", 69'(expired_o), 69'b0001);
    chk("t1_irq", 69'(irq_o), 69'd1);
    chk("t1_idle_ready", 69'(cfg_ready_o), 69'd1);
    clear_all();
    chk("t1_irq_clr", 69'(irq_o), 69'd0);

    // 2: slot1=50, slot2=80 (slot2 arrives while waiting, counter reads 0)
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd49));
    exp_q.push_back(wr(32'h0, 32'h1));
    exp_q.push_back(rd(32'h8));
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd49));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd1, 1'b1, 1'b0, 32'd50);
    do_cfg(2'd2, 1'b1, 1'b0, 32'd80);
    drain();
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd29));
    exp_q.push_back(wr(32'h0, 32'h1));
    fire_irq('0);
    chk("t2_expired_a", 69'(expired_o), 69'b0010);
    exp_q.push_back(wr(32'h0, 32'h2));
    fire_irq('0);
    settle(6);
    chk("t2_expired_b", 69'(expired_o), 69'b0110);
    clear_all();

    // 3: slot3 periodic 20, three rounds, set-vs-clear in round 2
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd19));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd3, 1'b1, 1'b1, 32'd20);
    drain();
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(wr(32'h0, 32'h2));
      exp_q.push_back(wr(32'h0, 32'h2));
      exp_q.push_back(wr(32'h4, 32'd19));
      exp_q.push_back(wr(32'h0, 32'h1));
      fire_irq((r == 1) ? 4'b1000 : 4'b0000);
      chk("t3_expired", 69'(expired_o), 69'b1000);
      if (r == 0) clear_all();
    end
    exp_q.push_back(rd(32'h8));
    exp_q.push_back(wr(32'h0, 32'h2));
    do_cfg(2'd3, 1'b0, 1'b0, 32'd0);
    drain();
    settle(6);
    chk("t3_disarm_idle", 69'(cfg_ready_o), 69'd1);
    chk("t3_disarm_keeps_flag", 69'(expired_o), 69'b1000);
    clear_all();

    // 4: counter read ages slot0 1000 -> 600 while slot1=10 is added
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd999));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd0, 1'b1, 1'b0, 32'd1000);
    drain();
    tmr_data_i = 32'd400;
    exp_q.push_back(rd(32'h8));
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd9));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd1, 1'b1, 1'b0, 32'd10);
    drain();
    tmr_data_i = 32'd0;
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd589));
    exp_q.push_back(wr(32'h0, 32'h1));
    fire_irq('0);
    chk("t4_expired", 69'(expired_o), 69'b0010);
    exp_q.push_back(rd(32'h8));
    exp_q.push_back(wr(32'h0, 32'h2));
    do_cfg(2'd0, 1'b0, 1'b0, 32'd0);
    drain();
    settle(6);

    // Random one-shot delay on slot2
    d = $urandom_range(5000, 2);
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, d - 32'd1));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd2, 1'b1, 1'b0, d);
    drain();
    exp_q.push_back(wr(32'h0, 32'h2));
    fire_irq('0);
    settle(6);
    chk("rand_expired", 69'(expired_o), 69'b0110);
    clear_all();

    // 5: delay 0 -> cmp 0; irq beats a same-cycle cfg
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd0));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd2, 1'b1, 1'b0, 32'd0);
    drain();
    exp_q.push_back(wr(32'h0, 32'h2));
    cfg_valid_i    = 1'b1;
    cfg_slot_i     = 2'd0;
    cfg_enable_i   = 1'b1;
    cfg_periodic_i = 1'b0;
    cfg_delay_i    = 32'd5;
    tmr_irq_i      = 1'b1;
    @(negedge clk);
    chk("t5_ready_irq", 69'(cfg_ready_o), 69'd0);
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
    tmr_irq_i   = 1'b0;
    drain();
    settle(7);
    chk("t5_expired", 69'(expired_o), 69'b0100);
    chk("t5_idle_ready", 69'(cfg_ready_o), 69'd1);

    // 6: reset while waiting on slot0=300 (flag bit2 still set)
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd299));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd0, 1'b1, 1'b0, 32'd300);
    drain();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_bus", {tmr_we_o, tmr_sel_o, tmr_addr_o, tmr_data_o}, 69'd0);
    chk("t6_rst_ready", 69'(cfg_ready_o), 69'd0);
    @(posedge clk); #1;
    chk("t6_rst_expired", 69'(expired_o), 69'd0);
    chk("t6_rst_irq", 69'(irq_o), 69'd0);
    exp_q.push_back(wr(32'h0, 32'h2));
    rst = 1'b0;
    drain();
    settle(6);
    chk("t6_idle_ready", 69'(cfg_ready_o), 69'd1);
    chk("t6_expired", 69'(expired_o), 69'd0);
    // slot0 must be gone: only the new 500-tick slot is programmed
    exp_q.push_back(wr(32'h0, 32'h2));
    exp_q.push_back(wr(32'h4, 32'd499));
    exp_q.push_back(wr(32'h0, 32'h1));
    do_cfg(2'd1, 1'b1, 1'b0, 32'd500);
    drain();
    settle(4);
    chk("queue_end", 69'(exp_q.size()), 69'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
